// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: issues word-aligned fetch addresses to the core,
// follows redirects, counts accepted fetches and halts at END_PC.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] END_PC   = 32'h0000_00FC,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               fetch_ready,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               fetch_valid,
  output logic [31:0]        fetch_pc,
  output logic [COUNT_W-1:0] fetch_count,
  output logic               halted,
  output logic               misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT,
    S_ERROR
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_pc;
  logic [31:0]          w_pc_next;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_valid;
  logic                 r_halted;
  logic                 r_err;
  logic                 w_xfer;
  logic                 w_misalign;
  logic                 w_cnt_sat;

  assign w_xfer     = (r_state == S_FETCH) && fetch_ready;
  assign w_misalign = redirect_pc[1:0] != 2'b00;
  assign w_cnt_sat  = &r_count;

  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    unique case (r_state)
      S_IDLE: begin
        w_pc_next = RESET_PC;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        unique case (1'b1)
          redirect_valid && w_misalign: begin
            w_next = S_ERROR;
          end
          redirect_valid && !w_misalign: begin
            w_pc_next = redirect_pc;
          end
          !redirect_valid && w_xfer && (r_pc == END_PC): begin
            w_next = S_HALT;
          end
          !redirect_valid && w_xfer && (r_pc != END_PC): begin
            w_pc_next = r_pc + 32'd4;
          end
          default: begin
            w_pc_next = r_pc;
          end
        endcase
      end
      S_HALT:  w_next = S_HALT;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pc     <= w_pc_next;
      r_valid  <= (w_next == S_FETCH);
      r_halted <= (w_next == S_HALT);
      r_err    <= (w_next == S_ERROR);
      if (w_xfer && !w_cnt_sat) r_count <= r_count + COUNT_W'(1);
    end
  end

  assign fetch_valid  = r_valid;
  assign fetch_pc     = r_pc;
  assign fetch_count  = r_count;
  assign halted       = r_halted;
  assign misalign_err = r_err;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: reference model feeds an expected-output
// queue at drive time; entries are popped and compared after each edge.
module tb_pc_fetch_sequencer;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          fetch_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] fetch_count;
  logic          halted;
  logic          misalign_err;

  int n_chk = 0;
  int n_err = 0;
  int n_cyc = 0;

  int            m_st;
  logic [31:0]   m_pc;
  logic [CW-1:0] m_cnt;
  logic [42:0]   q[$];

  localparam logic [42:0] RST_VAL = 43'd0;

  pc_fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .END_PC  (32'h0000_00FC),
    .COUNT_W (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fetch_ready   (fetch_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_count   (fetch_count),
    .halted        (halted),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [42:0] obs();
    return {fetch_valid, halted, misalign_err, fetch_count, fetch_pc};
  endfunction

  function automatic logic [42:0] mexp();
    return {m_st == 1, m_st == 2, m_st == 3, m_cnt, m_pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    m_st  = 0;
    m_pc  = 32'h0;
    m_cnt = '0;
    q.delete();
  endtask

  task automatic model_step(input logic s, input logic r,
                            input logic rv, input logic [31:0] rpc);
    bit x;
    x = (m_st == 1) && r;
    if (x && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    case (m_st)
      0: if (s) m_st = 1;
      1: begin
        if (rv && rpc[1:0] != 2'b00) m_st = 3;
        else if (rv) m_pc = rpc;
        else if (x && m_pc == 32'hFC) m_st = 2;
        else if (x) m_pc = m_pc + 32'd4;
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input logic s, input logic r,
                     input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    start          = s;
    fetch_ready    = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step(s, r, rv, rpc);
    q.push_back(mexp());
    @(posedge clk);
    #1;
    n_cyc++;
    if (q.size() == 0) chk("q_empty", 64'd1, 64'd0);
    else chk($sformatf("cyc%0d", n_cyc), 64'(obs()), 64'(q.pop_front()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_rst();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_rst();
    #1;
    chk("reset_vals", 64'(obs()), 64'(RST_VAL));
    @(negedge clk);
    reset = 1'b1;

    // basic sequential fetch
    cyc(1, 1, 0, 0);
    chk("start_pc", fetch_pc, 32'h0);
    chk("start_valid", fetch_valid, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    chk("count4", fetch_count, 4);
    chk("pc16", fetch_pc, 32'h10);
    chk("no_halt", halted, 0);

    // stall, redirect on transfer, misaligned redirect
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("stall_pc", fetch_pc, 32'h8);
    chk("stall_valid", fetch_valid, 1);
    cyc(0, 1, 1, 32'h40);
    chk("redir_pc", fetch_pc, 32'h40);
    chk("redir_cnt", fetch_count, 3);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h42);
    chk("mis_err", misalign_err, 1);
    chk("mis_pc", fetch_pc, 32'h44);
    chk("mis_valid", fetch_valid, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h80);
    chk("err_sticky", 64'(obs()), {21'd0, 43'h1_0400_0000_44});

    // run to END_PC
    do_reset();
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 1, 0, 0);
    chk("halt", halted, 1);
    chk("halt_cnt", fetch_count, 64);
    chk("halt_pc", fetch_pc, 32'hFC);
    cyc(1, 1, 1, 32'h10);
    cyc(0, 1, 0, 0);
    chk("halt_valid", fetch_valid, 0);

    // redirect coincident with END_PC transfer, then saturation
    do_reset();
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 63; i++) cyc(0, 1, 0, 0);
    chk("pre_end_pc", fetch_pc, 32'hFC);
    cyc(0, 1, 1, 32'h10);
    chk("end_redir_halt", halted, 0);
    chk("end_redir_pc", fetch_pc, 32'h10);
    chk("end_redir_cnt", fetch_count, 64);
    for (int i = 0; i < 200; i++) cyc(0, 1, 1, 32'h0);
    chk("cnt_sat", fetch_count, 8'hFF);

    // address wrap
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_pre", fetch_pc, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0);
    chk("wrap_pc", fetch_pc, 32'h0);

    // asynchronous reset mid-cycle
    cyc(0, 1, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", 64'(obs()), 64'(RST_VAL));
    model_rst();
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 1, 0, 0);
    chk("idle_after_rst", fetch_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
